// File: rtl/video24bit_in_pack.sv
// video24bit_in_pack: captures vsync/de framed 24-bit RGB, packs 8 pixels into three 64-bit DDR words
// Latency: a completed word appears on wr_data/wr_data_en one pclk after its last contributing pixel
// Backpressure: none toward the video source; a word meeting sync_fifo_full=1 is dropped and overflow sticks
module video24bit_in_pack #(
   parameter int ADDR_BITS = 25
) (
   input  logic                 pclk,
   input  logic                 prst_n,
   input  logic                 invsync,
   input  logic                 inhsync,
   input  logic                 inde,
   input  logic [23:0]          indata,
   input  logic [23:0]          video_width,
   input  logic [11:0]          video_height,
   input  logic [ADDR_BITS-1:0] video_baseaddr,
   input  logic                 sync_fifo_full,
   output logic                 wr_req,
   output logic [63:0]          wr_data,
   output logic                 wr_data_en,
   output logic [ADDR_BITS-1:0] baseaddr,
   output logic [23:0]          ddr_line_length,
   output logic [11:0]          ddr_col_length,
   output logic                 req_end,
   output logic                 overflow
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FRAME = 3'd1,
      BLK   = 3'd2,
      LINE  = 3'd3,
      FLUSH = 3'd4,
      LEND  = 3'd5,
      WDE   = 3'd6,
      FEND  = 3'd7
   } state_t;

   state_t               state;
   logic [11:0]          w_lat;
   logic [11:0]          h_lat;
   logic [ADDR_BITS-1:0] ba_lat;
   logic                 invsync_d;
   logic                 vs_rise;
   logic                 vs_fall;
   logic [11:0]          pix_cnt;
   logic [11:0]          line_cnt;
   logic [2:0]           phase;
   logic [63:0]          acc;
   logic [63:0]          acc_nxt;
   logic [63:0]          word;
   logic                 word_done;
   logic                 take;
   logic [11:0]          cnt_after;
   logic [2:0]           phase_after;
   logic                 emit;
   logic [63:0]          emit_word;
   logic [13:0]          len_sum;
   logic                 unused_ok;

   // hsync is not needed for framing; only the low 12 bits of the width are meaningful
   assign unused_ok = ^{inhsync, video_width[23:12]};

   assign vs_rise = invsync & ~invsync_d;
   assign vs_fall = ~invsync & invsync_d;

   // 3*W bytes per line, rounded up to whole 64-bit words
   assign len_sum = ({2'b00, w_lat} * 14'd3) + 14'd7;

   // a pixel is taken only while waiting for/inside a line and the line is not yet W pixels long
   assign take        = inde && (pix_cnt < w_lat) && ((state == BLK) || (state == LINE));
   assign cnt_after   = take ? (pix_cnt + 12'd1) : pix_cnt;
   assign phase_after = take ? (phase + 3'd1) : phase;
   assign emit        = (take && word_done) || (state == FLUSH);
   assign emit_word   = (state == FLUSH) ? acc : word;

   // byte-stream packer: acc holds the partial word, unused low bits kept at zero
   always_comb begin
      acc_nxt   = acc;
      word      = 64'd0;
      word_done = 1'b0;
      case (phase)
         3'd0: acc_nxt = {indata, 40'd0};
         3'd1: acc_nxt[39:16] = indata;
         3'd2: begin
            word      = {acc[63:16], indata[23:8]};
            word_done = 1'b1;
            acc_nxt   = {indata[7:0], 56'd0};
         end
         3'd3: acc_nxt[55:32] = indata;
         3'd4: acc_nxt[31:8] = indata;
         3'd5: begin
            word      = {acc[63:8], indata[23:16]};
            word_done = 1'b1;
            acc_nxt   = {indata[15:0], 48'd0};
         end
         3'd6: acc_nxt[47:24] = indata;
         default: begin
            word      = {acc[63:24], indata};
            word_done = 1'b1;
            acc_nxt   = 64'd0;
         end
      endcase
   end

   // frame geometry latched during vsync and presented as registered request fields
   always_ff @(posedge pclk) begin
      if (!prst_n) begin
         invsync_d       <= 1'b0;
         w_lat           <= 12'd0;
         h_lat           <= 12'd0;
         ba_lat          <= '0;
         baseaddr        <= '0;
         ddr_col_length  <= 12'd0;
         ddr_line_length <= 24'd0;
      end else begin
         invsync_d <= invsync;
         if (invsync) begin
            w_lat  <= video_width[11:0];
            h_lat  <= video_height;
            ba_lat <= video_baseaddr;
         end
         baseaddr        <= ba_lat;
         ddr_col_length  <= h_lat;
         ddr_line_length <= {13'd0, len_sum[13:3]};
      end
   end

   // frame/line sequencer with the packer state and registered write-port outputs
   always_ff @(posedge pclk) begin
      if (!prst_n) begin
         state      <= IDLE;
         pix_cnt    <= 12'd0;
         line_cnt   <= 12'd0;
         phase      <= 3'd0;
         acc        <= 64'd0;
         wr_req     <= 1'b0;
         req_end    <= 1'b0;
         wr_data    <= 64'd0;
         wr_data_en <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         wr_req     <= 1'b0;
         req_end    <= 1'b0;
         wr_data_en <= 1'b0;
         if (vs_rise) begin
            // a new vsync aborts whatever frame was in progress
            state    <= IDLE;
            overflow <= 1'b0;
            pix_cnt  <= 12'd0;
            line_cnt <= 12'd0;
            phase    <= 3'd0;
            acc      <= 64'd0;
         end else begin
            if (emit) begin
               if (sync_fifo_full) begin
                  overflow <= 1'b1;
               end else begin
                  wr_data    <= emit_word;
                  wr_data_en <= 1'b1;
               end
            end
            case (state)
               IDLE: begin
                  if (vs_fall) begin
                     state  <= FRAME;
                     wr_req <= 1'b1;
                  end
               end
               FRAME: begin
                  line_cnt <= 12'd0;
                  pix_cnt  <= 12'd0;
                  phase    <= 3'd0;
                  acc      <= 64'd0;
                  if (h_lat == 12'd0) begin
                     state   <= FEND;
                     req_end <= 1'b1;
                  end else begin
                     state <= BLK;
                  end
               end
               BLK: begin
                  if (take) begin
                     acc     <= acc_nxt;
                     phase   <= phase_after;
                     pix_cnt <= cnt_after;
                  end
                  if (inde) begin
                     state <= LINE;
                  end
               end
               LINE: begin
                  if (take) begin
                     acc     <= acc_nxt;
                     phase   <= phase_after;
                     pix_cnt <= cnt_after;
                  end
                  if (!inde || (cnt_after >= w_lat)) begin
                     state <= (phase_after != 3'd0) ? FLUSH : LEND;
                  end
               end
               FLUSH: begin
                  acc   <= 64'd0;
                  phase <= 3'd0;
                  state <= LEND;
               end
               LEND: begin
                  line_cnt <= line_cnt + 12'd1;
                  pix_cnt  <= 12'd0;
                  phase    <= 3'd0;
                  acc      <= 64'd0;
                  if ((line_cnt + 12'd1) == h_lat) begin
                     state   <= FEND;
                     req_end <= 1'b1;
                  end else begin
                     state <= WDE;
                  end
               end
               WDE: begin
                  if (!inde) begin
                     state <= BLK;
                  end
               end
               FEND: state <= FEND;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_video24bit_in_pack.sv
// tb_video24bit_in_pack: frames of random and directed video against a byte-stream reference model
// Latency: expects each word one pclk after its completing pixel (directed), order/content everywhere
// Backpressure: sync_fifo_full is held per line (or a short window) and dropped words are removed
module tb_video24bit_in_pack;

   localparam int AB = 25;

   logic          pclk;
   logic          prst_n;
   logic          invsync;
   logic          inhsync;
   logic          inde;
   logic [23:0]   indata;
   logic [23:0]   video_width;
   logic [11:0]   video_height;
   logic [AB-1:0] video_baseaddr;
   logic          sync_fifo_full;
   logic          wr_req;
   logic [63:0]   wr_data;
   logic          wr_data_en;
   logic [AB-1:0] baseaddr;
   logic [23:0]   ddr_line_length;
   logic [11:0]   ddr_col_length;
   logic          req_end;
   logic          overflow;

   video24bit_in_pack #(.ADDR_BITS(AB)) dut (
      .pclk            (pclk),
      .prst_n          (prst_n),
      .invsync         (invsync),
      .inhsync         (inhsync),
      .inde            (inde),
      .indata          (indata),
      .video_width     (video_width),
      .video_height    (video_height),
      .video_baseaddr  (video_baseaddr),
      .sync_fifo_full  (sync_fifo_full),
      .wr_req          (wr_req),
      .wr_data         (wr_data),
      .wr_data_en      (wr_data_en),
      .baseaddr        (baseaddr),
      .ddr_line_length (ddr_line_length),
      .ddr_col_length  (ddr_col_length),
      .req_end         (req_end),
      .overflow        (overflow)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          req_cnt = 0;
   int          end_cnt = 0;
   int          hold_err = 0;
   int          p2_cyc = 0;
   logic        rst_seen = 1'b1;
   logic [63:0] last_dat = 64'd0;
   logic [63:0] exp_q[$];
   logic [63:0] got_q[$];
   int          got_cyc[$];
   logic [23:0] line_pix [0:31];

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   always @(posedge pclk) begin
      cyc      <= cyc + 1;
      rst_seen <= !prst_n;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   // scoreboard: every strobe must match the next word the model predicted
   always @(negedge pclk) begin
      if (wr_req === 1'b1) req_cnt++;
      if (req_end === 1'b1) end_cnt++;
      if (wr_data_en === 1'b1) begin
         got_q.push_back(wr_data);
         got_cyc.push_back(cyc);
         chk("word_expected", 64'(exp_q.size() > 0), 64'd1);
         if (exp_q.size() > 0) chk("word", wr_data, exp_q.pop_front());
      end else if (!rst_seen && wr_data !== last_dat) begin
         hold_err++;
      end
      last_dat = wr_data;
   end

   // reference: accepted pixels become an R,G,B byte stream, zero-padded into big-endian 64-bit words
   task automatic push_words(input int n, input int skip);
      logic [7:0]  b[$];
      logic [63:0] wd;
      for (int i = 0; i < n; i++) begin
         b.push_back(line_pix[i][23:16]);
         b.push_back(line_pix[i][15:8]);
         b.push_back(line_pix[i][7:0]);
      end
      while (b.size() % 8 != 0) b.push_back(8'h00);
      for (int k = 0; k < b.size() / 8; k++) begin
         wd = 64'd0;
         for (int j = 0; j < 8; j++) wd = {wd[55:0], b[k*8+j]};
         if (k != skip) exp_q.push_back(wd);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_wr_req"}, 64'(wr_req), 64'd0);
      chk({tag, "_wr_data"}, wr_data, 64'd0);
      chk({tag, "_wr_data_en"}, 64'(wr_data_en), 64'd0);
      chk({tag, "_baseaddr"}, 64'(baseaddr), 64'd0);
      chk({tag, "_line_len"}, 64'(ddr_line_length), 64'd0);
      chk({tag, "_col_len"}, 64'(ddr_col_length), 64'd0);
      chk({tag, "_req_end"}, 64'(req_end), 64'd0);
      chk({tag, "_overflow"}, 64'(overflow), 64'd0);
   endtask

   // pat: 0 random, 1 = 0x111111*(i+1), 2 = short fixed list
   task automatic run_frame(input int w, input int h, input logic [AB-1:0] ba, input int de_len,
                            input int pat, input bit rnd_full, input int drop_idx,
                            input int abort_after, input int rst_at);
      bit any_drop = 1'b0;
      bit dead = 1'b0;
      bit line_full;
      int n;
      int dp;
      logic [23:0] lst [0:4];
      lst[0] = 24'hAABBCC; lst[1] = 24'h010203; lst[2] = 24'h040506;
      lst[3] = 24'h070809; lst[4] = 24'h0A0B0C;
      dp = (drop_idx == 0) ? 2 : (drop_idx == 1) ? 5 : 7;
      video_width    = {12'($urandom), 12'(w)};
      video_height   = 12'(h);
      video_baseaddr = ba;
      invsync = 1'b1;
      tick(); tick();
      chk("ovf_clr", 64'(overflow), 64'd0);
      tick();
      req_cnt = 0;
      end_cnt = 0;
      invsync = 1'b0;
      tick();
      video_width    = 24'($urandom);
      video_height   = 12'($urandom);
      video_baseaddr = AB'($urandom);
      tick(); tick();
      chk("cfg_base", 64'(baseaddr), 64'(ba));
      chk("cfg_col", 64'(ddr_col_length), 64'(h));
      chk("cfg_len", 64'(ddr_line_length), 64'((3 * w + 7) / 8));
      for (int ln = 0; ln < h + 1 && !dead; ln++) begin
         if (abort_after > 0 && ln == abort_after) break;
         line_full = rnd_full ? ($urandom_range(0, 3) == 0) : 1'b0;
         sync_fifo_full = line_full;
         for (int i = 0; i < 32; i++)
            line_pix[i] = (pat == 1) ? 24'(32'h111111 * (i + 1)) :
                          (pat == 2 && i < 5) ? lst[i] : 24'($urandom);
         n = (de_len < w) ? de_len : w;
         if (ln < h) begin
            if (line_full && n > 0) any_drop = 1'b1;
            else if (!line_full) push_words(n, (ln == 0) ? drop_idx : -1);
            if (ln == 0 && drop_idx >= 0) any_drop = 1'b1;
         end
         tick(); tick();
         for (int i = 0; i < de_len; i++) begin
            inde   = 1'b1;
            indata = line_pix[i];
            if (ln == 0 && drop_idx >= 0) sync_fifo_full = (i >= dp - 1 && i <= dp + 1);
            if (ln == 0 && i == 2) p2_cyc = cyc;
            if (ln == 0 && i == rst_at) prst_n = 1'b0;
            tick();
            if (!prst_n) begin
               chk_zero("midrst");
               prst_n = 1'b1;
               exp_q.delete();
               dead = 1'b1;
            end
         end
         inde = 1'b0;
         if (ln == 0 && drop_idx >= 0) sync_fifo_full = 1'b0;
         repeat (5) tick();
      end
      sync_fifo_full = 1'b0;
      repeat (4) tick();
      chk("req_cnt", 64'(req_cnt), 64'd1);
      chk("end_cnt", 64'(end_cnt), (dead || abort_after > 0) ? 64'd0 : 64'd1);
      chk("ovf_end", 64'(overflow), 64'(any_drop));
      chk("words_left", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int g0;
      prst_n = 1'b0; invsync = 1'b0; inhsync = 1'b0; inde = 1'b0; indata = 24'd0;
      video_width = 24'd0; video_height = 12'd0; video_baseaddr = '0; sync_fifo_full = 1'b0;
      repeat (3) tick();
      chk_zero("reset");
      prst_n = 1'b1;
      tick();

      // 8x2 counting pattern: exact words and one-cycle latency
      g0 = got_q.size();
      run_frame(8, 2, 25'h0123456, 8, 1, 1'b0, -1, 0, -1);
      chk("t1_count", 64'(got_q.size() - g0), 64'd6);
      if (got_q.size() - g0 >= 3) begin
         chk("t1_w0", got_q[g0], 64'h1111112222223333);
         chk("t1_w1", got_q[g0+1], 64'h3344444455555566);
         chk("t1_w2", got_q[g0+2], 64'h6666777777888888);
         chk("t1_lat", 64'(got_cyc[g0]), 64'(p2_cyc + 1));
      end

      // 5-pixel line: second word comes from the flush
      g0 = got_q.size();
      run_frame(5, 1, 25'h1ABCDEF, 5, 2, 1'b0, -1, 0, -1);
      chk("t2_len", 64'(ddr_line_length), 64'd2);
      chk("t2_count", 64'(got_q.size() - g0), 64'd2);
      if (got_q.size() - g0 >= 2) begin
         chk("t2_w0", got_q[g0], 64'hAABBCC0102030405);
         chk("t2_w1", got_q[g0+1], 64'h060708090A0B0C00);
      end

      // de longer than W: extra pixels ignored
      g0 = got_q.size();
      run_frame(8, 2, 25'h0000100, 10, 0, 1'b0, -1, 0, -1);
      chk("t3_count", 64'(got_q.size() - g0), 64'd6);

      // FIFO full around the second word of line 0
      g0 = got_q.size();
      run_frame(8, 2, 25'h0000200, 8, 1, 1'b0, 1, 0, -1);
      chk("t4_count", 64'(got_q.size() - g0), 64'd5);
      if (got_q.size() - g0 >= 2) chk("t4_w1", got_q[g0+1], 64'h6666777777888888);

      // vsync mid-frame aborts; the following frame uses newly latched geometry
      run_frame(8, 4, 25'h0000300, 8, 0, 1'b0, -1, 1, -1);
      run_frame(6, 2, 25'h1555555, 6, 0, 1'b0, -1, 0, -1);

      // reset mid-line, then a normal frame
      run_frame(8, 2, 25'h0000400, 8, 0, 1'b0, -1, 0, 1);
      run_frame(7, 3, 25'h0AAAAAA, 9, 0, 1'b0, -1, 0, -1);

      // random geometry, de length and per-line FIFO full
      repeat (12) begin
         run_frame($urandom_range(0, 20), $urandom_range(0, 3), AB'($urandom),
                   $urandom_range(1, 24), 0, 1'b1, -1, 0, -1);
      end

      chk("hold", 64'(hold_err), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule
